// File: rtl/bit_reorder_pipe_pkg.sv
// Shared encodings for the bit-reorder pipe: beat permutation modes and
// skid-buffer FSM states (the bench reuses both).
package bit_reorder_pipe_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_REV   = 2'd1,
      MODE_BSWAP = 2'd2,
      MODE_BREV8 = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/bit_reorder_perm.sv
// Purely combinational per-beat permutation: pass, full bit reversal,
// byte swap, or bit reversal inside each byte.
module bit_reorder_perm
   import bit_reorder_pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data_i,
   input  mode_e            mode_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] rev;
   logic [WIDTH-1:0] bswap;
   logic [WIDTH-1:0] brev8;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign rev[i] = data_i[WIDTH-1-i];
   end

   for (genvar b = 0; b < NB; b++) begin : g_byte
      assign bswap[8*b +: 8] = data_i[8*(NB-1-b) +: 8];
      for (genvar k = 0; k < 8; k++) begin : g_bit
         assign brev8[8*b+k] = data_i[8*b+7-k];
      end
   end

   // Select the permuted view for this beat
   always_comb begin
      data_o = data_i;
      case (mode_i)
         MODE_REV:   data_o = rev;
         MODE_BSWAP: data_o = bswap;
         MODE_BREV8: data_o = brev8;
         default:    data_o = data_i;
      endcase
   end

endmodule

// File: rtl/bit_reorder_pipe.sv
// Registered bit-reorder stage with a 2-entry skid buffer (main + skid).
// Words are permuted on the way in, so both registers hold final data.
// in_ready/out_valid are registered FSM outputs: no comb path from out_ready.
module bit_reorder_pipe
   import bit_reorder_pipe_pkg::*;
#(
   parameter int WIDTH = 32,   // multiple of 8, >= 8
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] beat_cnt
);

   state_e           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] perm_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             in_hs;
   logic             out_hs;

   assign in_hs  = in_valid && in_ready_q;
   assign out_hs = out_valid_q && out_ready;

   bit_reorder_perm #(
      .WIDTH (WIDTH)
   ) u_perm (
      .data_i (in_data),
      .mode_i (mode_e'(in_mode)),
      .data_o (perm_d)
   );

   // Skid FSM: state, registered handshake outputs and storage loads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_hs) begin
                  main_q      <= perm_d;
                  state_q     <= ST_ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ST_ONE: begin
               if (in_hs && !out_hs) begin
                  skid_q     <= perm_d;
                  state_q    <= ST_FULL;
                  in_ready_q <= 1'b0;
               end else if (in_hs && out_hs) begin
                  main_q <= perm_d;
               end else if (out_hs) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain can happen
               if (out_hs) begin
                  main_q     <= skid_q;
                  state_q    <= ST_ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Next beat count: one per output handshake, wraps naturally
   always_comb begin
      cnt_d = cnt_q;
      if (out_hs) cnt_d = cnt_q + CNT_W'(1);
   end

   // Beat counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_bit_reorder_pipe.sv
// Directed + randomized checks for bit_reorder_pipe: a 32-bit/16-bit-counter
// instance and an 8-bit/4-bit-counter instance for width and wrap corners.
module tb_bit_reorder_pipe;
   import bit_reorder_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [1:0]  in_mode;
   logic [15:0] beat_cnt;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  in_data8, out_data8;
   logic [1:0]  in_mode8;
   logic [3:0]  beat_cnt8;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bit_reorder_pipe #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .beat_cnt(beat_cnt)
   );

   bit_reorder_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .beat_cnt(beat_cnt8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_perm(input logic [31:0] d, input logic [1:0] m);
      logic [31:0] r;
      case (m)
         2'd1: r = {<<{d}};
         2'd2: r = {<<8{d}};
         2'd3: begin
            for (int b = 0; b < 4; b++) r[8*b +: 8] = {<<{d[8*b +: 8]}};
         end
         default: r = d;
      endcase
      return r;
   endfunction

   logic [31:0] exp_q[$];
   int          exp_cnt;
   logic        prev_stall;
   logic [31:0] prev_data;
   logic        ihs, ohs;

   initial begin
      in_valid = 0; in_data = '0; in_mode = 0; out_ready = 0;
      in_valid8 = 0; in_data8 = '0; in_mode8 = 0; out_ready8 = 0;
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // reset state
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_beat_cnt", beat_cnt, 0);

      // four modes back to back on one word
      out_ready = 1; in_valid = 1; in_data = 32'h12345678; in_mode = 0;
      @(negedge clk);
      chk("mode_pass", out_data, 32'h12345678);
      chk("mode_pass_vld", out_valid, 1);
      in_mode = 1;
      @(negedge clk);
      chk("mode_rev", out_data, 32'h1E6A2C48);
      chk("cnt_after1", beat_cnt, 1);
      in_mode = 2;
      @(negedge clk);
      chk("mode_bswap", out_data, 32'h78563412);
      in_mode = 3;
      @(negedge clk);
      chk("mode_brev8", out_data, 32'h482C6A1E);
      in_valid = 0;
      @(negedge clk);
      chk("modes_drained", out_valid, 0);
      chk("modes_cnt", beat_cnt, 4);
      exp_cnt = 4;

      // back-pressure: two absorbed, third held off
      out_ready = 0; in_valid = 1; in_mode = 0; in_data = 32'hA1;
      @(negedge clk);
      chk("bp_first", out_data, 32'hA1);
      chk("bp_rdy_one", in_ready, 1);
      in_data = 32'hB2;
      @(negedge clk);
      chk("bp_full_rdy", in_ready, 0);
      chk("bp_hold1", out_data, 32'hA1);
      in_data = 32'hC3;
      @(negedge clk);
      chk("bp_full_rdy2", in_ready, 0);
      chk("bp_hold2", out_data, 32'hA1);
      out_ready = 1;
      @(negedge clk);
      chk("bp_second", out_data, 32'hB2);
      chk("bp_second_vld", out_valid, 1);
      chk("bp_rdy_back", in_ready, 1);
      @(negedge clk);
      chk("bp_third", out_data, 32'hC3);
      in_valid = 0;
      @(negedge clk);
      chk("bp_empty", out_valid, 0);
      chk("bp_cnt", beat_cnt, 7);
      exp_cnt = 7;

      // randomized stream with scoreboard and stall-stability checks
      prev_stall = 0; prev_data = '0;
      for (int c = 0; c < 300; c++) begin
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         in_mode   = 2'($urandom_range(0, 3));
         ihs = in_valid && in_ready;
         ohs = out_valid && out_ready;
         if (ohs) begin
            if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
            else chk("sb_data", out_data, exp_q.pop_front());
            exp_cnt++;
         end
         if (ihs) exp_q.push_back(ref_perm(in_data, in_mode));
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         @(negedge clk);
      end
      in_valid = 0; out_ready = 1;
      for (int c = 0; c < 10 && out_valid; c++) begin
         if (exp_q.size() == 0) chk("drain_unexpected", 1, 0);
         else chk("drain_data", out_data, exp_q.pop_front());
         exp_cnt++;
         @(negedge clk);
      end
      chk("drain_done", out_valid, 0);
      chk("drain_sb_empty", exp_q.size(), 0);
      chk("rand_cnt", beat_cnt, 32'(exp_cnt[15:0]));

      // WIDTH=8 corners and 4-bit counter wrap after 17 beats
      out_ready8 = 1;
      for (int i = 0; i < 17; i++) begin
         in_valid8 = 1;
         in_data8  = (i < 3) ? 8'h01 : 8'(i);
         in_mode8  = (i == 0) ? 2'd1 : (i == 1) ? 2'd3 : (i == 2) ? 2'd2 : 2'd0;
         @(negedge clk);
         if (i == 0) chk("w8_rev", out_data8, 8'h80);
         if (i == 1) chk("w8_brev8", out_data8, 8'h80);
         if (i == 2) chk("w8_bswap", out_data8, 8'h01);
      end
      in_valid8 = 0;
      @(negedge clk);
      chk("w8_empty", out_valid8, 0);
      chk("w8_cnt_wrap", beat_cnt8, 1);

      // fill to FULL, then async reset before any edge
      out_ready = 0; in_valid = 1; in_mode = 0; in_data = 32'hDEAD0001;
      @(negedge clk);
      in_data = 32'hDEAD0002;
      @(negedge clk);
      in_valid = 0;
      chk("pre_rst_full", in_ready, 0);
      #2 rst_n = 0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_beat_cnt", beat_cnt, 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_cnt8", beat_cnt8, 0);
      @(negedge clk);
      rst_n = 1;
      out_ready = 1;
      @(negedge clk);
      chk("post_rst_vld", out_valid, 0);
      chk("post_rst_cnt", beat_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bit_reorder_pipe.md
# bit_reorder_pipe

Parametrised, registered bit-reordering stage for streaming data paths. It accepts one WIDTH-bit word per handshake and applies a per-beat permutation: pass-through, full bit reversal, byte swap, or bit reversal within each byte. It buffers through a 2-entry skid stage, so full throughput is kept under back-pressure. It sits between any valid/ready producer and consumer where endianness or bit-order conversion is needed.

## Interface
Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8 and at least 8.
- CNT_W, 16, width of the output beat counter.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset. Reset is asynchronous and active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  input word.
- in_mode  in  2  permutation for this beat: 0 PASS, 1 REV (full reversal), 2 BSWAP (byte swap), 3 BREV8 (bit reversal within each byte).
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  permuted word.
- beat_cnt  out  CNT_W  number of completed output handshakes since reset; wraps modulo 2^CNT_W.

## Operation
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Mode handling: in_mode is sampled with in_data on the input handshake. The permutation is applied before storage, so each stored word is already final. A mode change between beats takes effect on the next accepted beat only.
- Permutation definitions, with i the bit index and b the byte index:
  - REV: out[i] = in[WIDTH-1-i].
  - BSWAP: out byte b = in byte (WIDTH/8-1-b).
  - BREV8: out[8b+k] = in[8b+7-k].
  - PASS: identity.
  - When WIDTH=8, BSWAP equals PASS and BREV8 equals REV.
- Storage: an output register (main) plus one skid register (skid), for 2 entries total.
- State machine, states EMPTY, ONE, FULL:
  - EMPTY → ONE on an input handshake.
  - ONE → EMPTY on an output handshake with no input handshake.
  - ONE → FULL on an input handshake with no output handshake; the word goes to skid.
  - ONE → ONE when input and output handshakes occur together; main loads the new word.
  - FULL → ONE on an output handshake; main loads from skid.
  - in_ready is deasserted in FULL, so no input is accepted there.
- Output signals:
  - in_ready = (state != FULL). It is a registered state decode with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - out_data is driven from main only.
- beat_cnt increments by 1 on every output handshake and wraps from 2^CNT_W-1 to 0.
- Ordering: words leave in strict acceptance order. None are dropped or duplicated.

## Timing
- Reset values (async assert, sync release): state EMPTY, out_valid 0, in_ready 1, out_data 0, skid 0, beat_cnt 0.
- Reset asserted mid-stream discards all buffered words immediately. No output handshake is counted for them.
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N. The earliest consumption is edge N+1.
- Throughput: 1 word/cycle while out_ready=1. While out_ready=0, up to 2 words are absorbed, then in_ready falls.
- After out_ready rises in FULL, in_ready reasserts one cycle later. No bubble is allowed on the output side.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- in_valid with in_ready=0 has no effect. Data on in_data is ignored unless a handshake occurs.

## Structure
- Shared package: mode encodings MODE_PASS/MODE_REV/MODE_BSWAP/MODE_BREV8 and a 2-bit mode typedef. The FSM state encoding is also shared for bench reuse.
- Sub-module bit_reorder_perm is the purely combinational permutation, parametrised by WIDTH, with inputs data and mode and output permuted data. It is instantiated once, on the input side.
- The top level holds the FSM, main/skid registers and beat counter.

## Test plan
- WIDTH=32, in_data 0x12345678, out_ready=1, modes 0..3 on successive beats → out_data 0x12345678, 0x1E6A2C48, 0x78563412, 0x482C6A1E on consecutive cycles. beat_cnt ends at 4.
- out_ready=0 while 3 words (0xA1, 0xB2, 0xC3 in PASS) are offered → first two accepted, in_ready=0 in FULL. Raising out_ready delivers 0xA1 then 0xB2 on back-to-back cycles, then 0xC3 is accepted.
- Continuous stream with random out_ready and in_valid, and random modes → scoreboard shows order preserved, no loss or duplication, and output stable while stalled.
- CNT_W=4, 17 output handshakes → beat_cnt reads 1 (wrap after 15).
- Assert rst_n low in FULL with out_ready=0 → out_valid=0, in_ready=1, beat_cnt=0 immediately, before any clock edge.
- WIDTH=8, in 0x01 in REV and BREV8, 0x01 in BSWAP → 0x80, 0x80, 0x01.
